// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush/freeze controller with a memory-wait FSM and timeout.
// Optional performance counters are built only when PIPELINE_PERF_CNT_EN is defined.
module pipeline_stall_ctrl #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic             sram_ready,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             freeze_all,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] wait_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W:0]   WAIT_LIMIT = (CNT_W+1)'(MAX_WAIT);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_tmr;
    logic [CNT_W-1:0] wait_tmr_nxt;
    logic             timeout_set;
    logic             mem_req;
    logic             tmr_expire;

    assign mem_req    = mem_r_en | mem_w_en;
    // The cycle being counted now is the one that reaches MAX_WAIT.
    assign tmr_expire = ({1'b0, wait_tmr} + (CNT_W+1)'(1)) >= WAIT_LIMIT;

    // State, timeout counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_tmr    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_tmr <= wait_tmr_nxt;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // Next-state and timeout counter update.
    always_comb begin
        state_nxt    = state;
        wait_tmr_nxt = wait_tmr;
        timeout_set  = 1'b0;
        case (state)
            RUN: begin
                if (mem_req && !sram_ready) begin
                    state_nxt    = MEM_WAIT;
                    wait_tmr_nxt = '0;
                end
            end
            MEM_WAIT: begin
                if (sram_ready) begin
                    state_nxt = RUN;
                end else if (tmr_expire) begin
                    state_nxt   = RUN;
                    timeout_set = 1'b1;
                end else if (wait_tmr != CNT_MAX) begin
                    wait_tmr_nxt = wait_tmr + CNT_W'(1);
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Control outputs: freeze beats branch flush beats hazard stall.
    always_comb begin
        freeze_pc    = 1'b0;
        freeze_if_id = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        freeze_all   = 1'b0;
        case (state)
            RUN: begin
                // Reset abandons any pending access, so no freeze while rst_n is low.
                freeze_all = rst_n && mem_req && !sram_ready;
                if (!freeze_all) begin
                    if (branch_taken) begin
                        flush_if_id  = 1'b1;
                        bubble_id_ex = 1'b1;
                    end else if (hazard_detected) begin
                        freeze_pc    = 1'b1;
                        freeze_if_id = 1'b1;
                        bubble_id_ex = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                freeze_all = !sram_ready;
            end
            default: freeze_all = 1'b0;
        endcase
    end

`ifdef PIPELINE_PERF_CNT_EN
    // Saturating per-cycle event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
            wait_cycles  <= '0;
        end else begin
            if (freeze_if_id && stall_cycles != CNT_MAX) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_if_id && flush_count != CNT_MAX) begin
                flush_count <= flush_count + CNT_W'(1);
            end
            if (freeze_all && wait_cycles != CNT_MAX) begin
                wait_cycles <= wait_cycles + CNT_W'(1);
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
    assign wait_cycles  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: vector table plus multi-cycle
// sequences, expected outputs queued at drive time and compared mid-cycle.
module tb_pipeline_stall_ctrl;

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned MAX_WAIT = 8;

    typedef struct packed {
        logic hz;
        logic br;
        logic mr;
        logic mw;
        logic rdy;
    } in_t;

    typedef struct packed {
        logic fpc;
        logic fifid;
        logic bub;
        logic flush;
        logic fall;
    } ctrl_t;

    typedef struct packed {
        in_t   in;
        ctrl_t exp;
    } vec_t;

    typedef struct packed {
        logic [15:0]      tag;
        ctrl_t            c;
        logic             to;
        logic [CNT_W-1:0] st;
        logic [CNT_W-1:0] fl;
        logic [CNT_W-1:0] wt;
    } exp_t;

    logic clk;
    logic rst_n;
    logic hazard_detected;
    logic branch_taken;
    logic mem_r_en;
    logic mem_w_en;
    logic sram_ready;
    logic freeze_pc;
    logic freeze_if_id;
    logic bubble_id_ex;
    logic flush_if_id;
    logic freeze_all;
    logic mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic [CNT_W-1:0] wait_cycles;

    int unsigned n_run  = 0;
    int unsigned n_fail = 0;
    logic [15:0] tag_ctr = '0;
    logic [CNT_W-1:0] m_st = '0;
    logic [CNT_W-1:0] m_fl = '0;
    logic [CNT_W-1:0] m_wt = '0;
    exp_t sb[$];

    pipeline_stall_ctrl #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .mem_r_en        (mem_r_en),
        .mem_w_en        (mem_w_en),
        .sram_ready      (sram_ready),
        .freeze_pc       (freeze_pc),
        .freeze_if_id    (freeze_if_id),
        .bubble_id_ex    (bubble_id_ex),
        .flush_if_id     (flush_if_id),
        .freeze_all      (freeze_all),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .wait_cycles     (wait_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int unsigned idx,
                                input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
        end
    endfunction

    function automatic ctrl_t dut_ctrl();
        return '{fpc: freeze_pc, fifid: freeze_if_id, bub: bubble_id_ex,
                 flush: flush_if_id, fall: freeze_all};
    endfunction

    // Counters the DUT should show: accumulated from earlier expected cycles.
    task automatic step(input in_t i, input ctrl_t c, input logic to);
        exp_t e;
        hazard_detected = i.hz;
        branch_taken    = i.br;
        mem_r_en        = i.mr;
        mem_w_en        = i.mw;
        sram_ready      = i.rdy;
        e.tag = tag_ctr;
        e.c   = c;
        e.to  = to;
`ifdef PIPELINE_PERF_CNT_EN
        e.st = m_st;
        e.fl = m_fl;
        e.wt = m_wt;
        if (c.fifid) m_st = m_st + CNT_W'(1);
        if (c.flush) m_fl = m_fl + CNT_W'(1);
        if (c.fall)  m_wt = m_wt + CNT_W'(1);
`else
        e.st = '0;
        e.fl = '0;
        e.wt = '0;
`endif
        sb.push_back(e);
        tag_ctr = tag_ctr + 16'd1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare half a cycle after the inputs were driven.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("ctrl", e.tag, 32'(dut_ctrl()), 32'(e.c));
            chk("mem_timeout", e.tag, 32'(mem_timeout), 32'(e.to));
            chk("stall_cycles", e.tag, 32'(stall_cycles), 32'(e.st));
            chk("flush_count", e.tag, 32'(flush_count), 32'(e.fl));
            chk("wait_cycles", e.tag, 32'(wait_cycles), 32'(e.wt));
        end
    end

    task automatic reset_checks(input int unsigned idx, input ctrl_t c);
        chk("rst_ctrl", idx, 32'(dut_ctrl()), 32'(c));
        chk("rst_timeout", idx, 32'(mem_timeout), 32'd0);
        chk("rst_cnt", idx, 32'(stall_cycles) | 32'(flush_count) | 32'(wait_cycles), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    localparam in_t I0 = '0;
    localparam ctrl_t C0 = '0;
    localparam ctrl_t C_ST = '{fpc: 1'b1, fifid: 1'b1, bub: 1'b1, flush: 1'b0, fall: 1'b0};
    localparam ctrl_t C_FL = '{fpc: 1'b0, fifid: 1'b0, bub: 1'b1, flush: 1'b1, fall: 1'b0};
    localparam ctrl_t C_FZ = '{fpc: 1'b0, fifid: 1'b0, bub: 1'b0, flush: 1'b0, fall: 1'b1};

    initial begin
        vec_t vecs[10];
        // in = {hz, br, mr, mw, rdy}; exp = {fpc, fifid, bub, flush, fall}
        vecs[0] = '{in: 5'b00000, exp: C0};
        vecs[1] = '{in: 5'b10000, exp: C_ST};
        vecs[2] = '{in: 5'b10000, exp: C_ST};
        vecs[3] = '{in: 5'b01000, exp: C_FL};
        vecs[4] = '{in: 5'b11000, exp: C_FL};
        vecs[5] = '{in: 5'b00101, exp: C0};
        vecs[6] = '{in: 5'b00011, exp: C0};
        vecs[7] = '{in: 5'b10101, exp: C_ST};
        vecs[8] = '{in: 5'b01011, exp: C_FL};
        vecs[9] = '{in: 5'b00001, exp: C0};

        rst_n = 1'b0;
        {hazard_detected, branch_taken, mem_r_en, mem_w_en, sram_ready} = '0;
        #3;
        reset_checks(0, C0);
        hazard_detected = 1'b1;
        #1;
        reset_checks(1, C_ST);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            step(vecs[k].in, vecs[k].exp, 1'b0);
        end

        // Load with 4-cycle wait; hazard/branch ignored while frozen.
        step(5'b11100, C_FZ, 1'b0);
        step(5'b10100, C_FZ, 1'b0);
        step(5'b11100, C_FZ, 1'b0);
        step(5'b10100, C_FZ, 1'b0);
        step(5'b10101, C0,   1'b0);
        step(5'b10000, C_ST, 1'b0);

        // Store with one wait cycle.
        step(5'b00010, C_FZ, 1'b0);
        step(5'b01011, C0,   1'b0);
        step(5'b01000, C_FL, 1'b0);

        // Timeout: request cycle + MAX_WAIT frozen wait cycles, then forced release.
        step(5'b00100, C_FZ, 1'b0);
        for (int k = 0; k < int'(MAX_WAIT); k++) begin
            step(5'b00100, C_FZ, 1'b0);
        end
        step(I0,       C0,   1'b1);
        step(5'b00101, C0,   1'b1);
        step(5'b10000, C_ST, 1'b1);
        step(I0,       C0,   1'b1);

        // Reset in the third wait cycle.
        step(5'b00100, C_FZ, 1'b1);
        step(5'b00100, C_FZ, 1'b1);
        step(5'b00100, C_FZ, 1'b1);
        {hazard_detected, branch_taken, mem_r_en, mem_w_en, sram_ready} = 5'b10100;
        #1;
        chk("wait3_ctrl", 0, 32'(dut_ctrl()), 32'(C_FZ));
        rst_n = 1'b0;
        #1;
        reset_checks(2, C_ST);
        m_st = '0;
        m_fl = '0;
        m_wt = '0;
        @(posedge clk);
        #1;
        reset_checks(3, C_ST);
        rst_n = 1'b1;

        step(I0,       C0,   1'b0);
        step(5'b01000, C_FL, 1'b0);
        step(5'b10000, C_ST, 1'b0);
        step(I0,       C0,   1'b0);

        for (int k = 0; k < 4 && sb.size() > 0; k++) begin
            @(posedge clk);
        end
        chk("sb_drain", 0, 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 255: maximum MEM_WAIT cycles before timeout.
REQ-002 Parameter CNT_W, default 16: width of the timeout counter and the performance counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 hazard_detected  input  1  RAW hazard flag from the hazard detection unit (ID stage).
REQ-006 branch_taken  input  1  taken branch resolved in EXE.
REQ-007 mem_r_en  input  1  MEM-stage load request.
REQ-008 mem_w_en  input  1  MEM-stage store request.
REQ-009 sram_ready  input  1  memory access complete; valid in the cycle it is sampled.
REQ-010 freeze_pc  output  1  hold the PC.
REQ-011 freeze_if_id  output  1  hold the IF/ID register.
REQ-012 bubble_id_ex  output  1  load a NOP (all control bits zero) into ID/EX.
REQ-013 flush_if_id  output  1  clear the IF/ID register.
REQ-014 freeze_all  output  1  hold every pipeline register and the PC.
REQ-015 mem_timeout  output  1  sticky error flag.
REQ-016 stall_cycles, flush_count, wait_cycles  output  CNT_W each  performance counters.

Function
REQ-017 FSM states: RUN and MEM_WAIT; encoding is free.
REQ-018 RUN to MEM_WAIT when (mem_r_en|mem_w_en)=1 and sram_ready=0.
REQ-019 An access with sram_ready=1 in the same cycle completes with zero wait and the FSM stays in RUN.
REQ-020 In MEM_WAIT, freeze_all=1 and every other control output is 0.
REQ-021 MEM_WAIT to RUN on the cycle after sram_ready=1; freeze_all is 0 in the sram_ready cycle itself.
REQ-022 The transition decision (REQ-018) is combinational from the inputs.
REQ-023 freeze_all is asserted in the same cycle as the access request when sram_ready=0.
REQ-024 In MEM_WAIT, hazard_detected and branch_taken are ignored; frozen stages re-present them after release.
REQ-025 RUN, branch_taken=1 (not freezing):
  - flush_if_id=1 and bubble_id_ex=1 for that cycle.
  - freeze_pc=0 and freeze_if_id=0.
  - branch_taken takes priority over hazard_detected.
REQ-026 RUN, hazard_detected=1, branch_taken=0 (not freezing): freeze_pc=1, freeze_if_id=1, bubble_id_ex=1.
REQ-027 Priority when simultaneous: freeze_all > branch flush > hazard stall.
REQ-028 Timeout counter:
  - clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
  - on reaching MAX_WAIT with sram_ready=0, sets mem_timeout and forces a return to RUN.
REQ-029 mem_timeout holds until reset.
REQ-030 Counter arithmetic is unsigned CNT_W-bit; all counters saturate at all-ones and never wrap.

Reset
REQ-031 On rst_n=0, immediately and independent of clk:
  - FSM goes to RUN.
  - timeout counter, mem_timeout and all performance counters go to 0.
REQ-032 During and after reset, outputs follow the RUN rules (REQ-025/026) applied to the current inputs.
REQ-033 Reset asserted mid-MEM_WAIT abandons the wait; freeze_all drops to 0 while rst_n=0.
REQ-034 Reset release is synchronous to the design's use of clk; the first state update occurs on the first rising edge with rst_n=1.

Configuration
REQ-035 Macro PIPELINE_PERF_CNT_EN controls the performance counters.
REQ-036 With PIPELINE_PERF_CNT_EN defined, increments are per cycle:
  - stall_cycles: each cycle with freeze_if_id=1.
  - flush_count: each cycle with flush_if_id=1.
  - wait_cycles: each cycle with freeze_all=1.
REQ-037 With PIPELINE_PERF_CNT_EN undefined, no counter registers exist and all three outputs are constant 0; all other behaviour is identical.

Verification
REQ-038 Hazard: hazard_detected=1 for 2 cycles, branch=0, no memory access -> freeze_pc=freeze_if_id=bubble_id_ex=1 in both cycles; stall_cycles=2.
REQ-039 Branch and hazard together: branch_taken=1 with hazard_detected=1 -> flush_if_id=1, bubble_id_ex=1, freeze_pc=0; flush_count=1, stall_cycles unchanged.
REQ-040 Zero-wait load: mem_r_en=1 with sram_ready=1 in the same cycle -> freeze_all never asserted; FSM stays in RUN.
REQ-041 Load wait: mem_r_en=1, sram_ready rises 4 cycles later -> freeze_all=1 for exactly 4 cycles; wait_cycles=4; hazard_detected=1 during the wait produces no bubble.
REQ-042 Timeout: MAX_WAIT=8, sram_ready held 0 -> mem_timeout=1 after 8 MEM_WAIT cycles; return to RUN; flag stays set until rst_n=0.
REQ-043 Reset mid-wait: rst_n=0 in the third MEM_WAIT cycle -> freeze_all=0 immediately and all counters=0; with the macro undefined, counters read 0 throughout.
